ads127l1x_frame_scheduler: RTL

Takes the latched per-channel packets and `data_ready` flag from the ADS127L1x TDM deserializer and streams them into the system clock domain. Each frame becomes a sequence of AXI-Stream beats, one per enabled channel, for the UDP packetizer. It synchronizes `data_ready`, snapshots all channels once per frame, and schedules enabled channels in ascending order. It also counts accepted frames and overruns.

---
 rtl/ads127l1x_frame_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ads127l1x_frame_scheduler.sv
// ads127l1x_frame_scheduler: streams each ADS127L1x TDM frame as one AXI-Stream beat per enabled channel.
// Optional frame header beat: define ADS127L1X_FRAME_HEADER_EN.
module ads127l1x_frame_scheduler #(
   parameter int BITS_PER_PACKET = 24,
   parameter int CHANNEL_COUNT   = 8,
   parameter int OUT_WIDTH       = 32
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     adc_data_ready,
   input  logic [CHANNEL_COUNT*BITS_PER_PACKET-1:0] ch_packets,
   input  logic [CHANNEL_COUNT-1:0]                 ch_enable,
   input  logic                                     enable,
   output logic [OUT_WIDTH-1:0]                     m_tdata,
   output logic                                     m_tvalid,
   input  logic                                     m_tready,
   output logic                                     m_tlast,
   output logic                                     busy,
   output logic [15:0]                              frame_count,
   output logic [15:0]                              overrun_count
);
   localparam int PW = CHANNEL_COUNT * BITS_PER_PACKET;

`ifdef ADS127L1X_FRAME_HEADER_EN
   typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t                   state_q;
   logic                     s1_q, s2_q, s3_q;
   logic [PW-1:0]            buf_q;
   logic [CHANNEL_COUNT-1:0] pend_q, pend_d;
   logic [OUT_WIDTH-1:0]     tdata_q;
   logic                     tvalid_q, tlast_q;
   logic [15:0]              fc_q, oc_q;
   logic                     rdy_rise, capture, fire;

   // Beat for the lowest pending channel: index nibble on top, packet at the bottom.
   function automatic logic [OUT_WIDTH-1:0] beat_data(input logic [CHANNEL_COUNT-1:0] mask,
                                                      input logic [PW-1:0] pk);
      logic [OUT_WIDTH-1:0] d;
      logic [3:0]           idx;
      idx = '0;
      for (int i = CHANNEL_COUNT - 1; i >= 0; i--)
         if (mask[i]) idx = 4'(i);
      d = '0;
      d[BITS_PER_PACKET-1:0] = pk[int'(idx)*BITS_PER_PACKET +: BITS_PER_PACKET];
      d[OUT_WIDTH-1 -: 4]    = idx;
      return d;
   endfunction

   function automatic logic one_left(input logic [CHANNEL_COUNT-1:0] mask);
      return $countones(mask) == 1;
   endfunction

`ifdef ADS127L1X_FRAME_HEADER_EN
   function automatic logic [OUT_WIDTH-1:0] hdr_data(input logic [15:0] fc);
      logic [OUT_WIDTH-1:0] d;
      d = '0;
      d[15:0]             = fc;
      d[OUT_WIDTH-1 -: 4] = 4'hF;
      return d;
   endfunction
`endif

   // Handshake qualifiers; pend_d drops the lowest set bit (the channel being sent).
   always_comb begin
      rdy_rise = s2_q & ~s3_q;
      capture  = (state_q == IDLE) & rdy_rise & enable & (|ch_enable);
      fire     = tvalid_q & m_tready;
      pend_d   = pend_q & (pend_q - CHANNEL_COUNT'(1));
   end

   // Two-flop synchronizer for data_ready plus a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= adc_data_ready;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Frame FSM: snapshot on capture, then one registered beat per pending channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         buf_q    <= '0;
         pend_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         fc_q     <= '0;
         oc_q     <= '0;
      end else begin
         if (rdy_rise && state_q != IDLE && oc_q != 16'hFFFF) oc_q <= oc_q + 16'd1;
         case (state_q)
            IDLE: if (capture) begin
               buf_q    <= ch_packets;
               pend_q   <= ch_enable;
               fc_q     <= fc_q + 16'd1;
               tvalid_q <= 1'b1;
`ifdef ADS127L1X_FRAME_HEADER_EN
               state_q  <= HDR;
               tdata_q  <= hdr_data(fc_q);
               tlast_q  <= 1'b0;
`else
               state_q  <= SEND;
               tdata_q  <= beat_data(ch_enable, ch_packets);
               tlast_q  <= one_left(ch_enable);
`endif
            end
`ifdef ADS127L1X_FRAME_HEADER_EN
            HDR: if (fire) begin
               state_q <= SEND;
               tdata_q <= beat_data(pend_q, buf_q);
               tlast_q <= one_left(pend_q);
            end
`endif
            SEND: if (fire) begin
               pend_q  <= pend_d;
               tdata_q <= (pend_d == '0) ? '0 : beat_data(pend_d, buf_q);
               tlast_q <= one_left(pend_d);
               if (pend_d == '0) begin
                  state_q  <= IDLE;
                  tvalid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_tdata       = tdata_q;
   assign m_tvalid      = tvalid_q;
   assign m_tlast       = tlast_q;
   assign busy          = state_q != IDLE;
   assign frame_count   = fc_q;
   assign overrun_count = oc_q;
endmodule
